// File: rtl/key_tone_decoder.sv
// Scan-code note decoder: debounced PS/2-style make/break codes drive a square-wave tone with an envelope.
// Optional macro KEY_TONE_DECAY_EN builds the RELEASE state with a linear amplitude decay.
module key_tone_decoder #(
  parameter int unsigned STABLE_CYC = 2,
  parameter int unsigned PRESCALE   = 64,
  parameter int unsigned DECAY_CYC  = 4096,
  parameter int unsigned AMP_MAX    = 255
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] key_code,
  output logic [3:0] note_idx,
  output logic       key_on,
  output logic       key_off,
  output logic       active,
  output logic       tone_sq,
  output logic [7:0] wave_out
);

  if (STABLE_CYC == 0 || STABLE_CYC > 15) begin : g_bad_stable
    $error("STABLE_CYC out of range 1..15");
  end
  if (PRESCALE < 2 || PRESCALE > 1023) begin : g_bad_prescale
    $error("PRESCALE out of range 2..1023");
  end
  if (DECAY_CYC == 0 || DECAY_CYC > 65535) begin : g_bad_decay
    $error("DECAY_CYC out of range 1..65535");
  end
  if (AMP_MAX == 0 || AMP_MAX > 255) begin : g_bad_amp
    $error("AMP_MAX out of range 1..255");
  end

  localparam logic [7:0] REL_CODE  = 8'hF0;
  localparam logic [3:0] STAB_MAX  = 4'(STABLE_CYC - 1);
  localparam logic [9:0] PRESC_MAX = 10'(PRESCALE - 1);
  localparam logic [7:0] AMP_INIT  = 8'(AMP_MAX);

`ifdef KEY_TONE_DECAY_EN
  localparam logic [15:0] DECAY_MAX = 16'(DECAY_CYC - 1);
  typedef enum logic [1:0] {IDLE, PLAY, RELEASE} state_t;
`else
  typedef enum logic {IDLE, PLAY} state_t;
`endif

  typedef struct packed {
    logic        hit;
    logic [3:0]  idx;
    logic [11:0] half;
  } note_t;

  function automatic note_t note_lookup(input logic [7:0] code);
    note_t n;
    n = '0;
    case (code)
      8'h2B:   n = '{1'b1, 4'd1, 12'd1493};
      8'h34:   n = '{1'b1, 4'd2, 12'd1330};
      8'h33:   n = '{1'b1, 4'd3, 12'd1185};
      8'h3B:   n = '{1'b1, 4'd4, 12'd1118};
      8'h42:   n = '{1'b1, 4'd5, 12'd996};
      8'h4B:   n = '{1'b1, 4'd6, 12'd888};
      8'h4C:   n = '{1'b1, 4'd7, 12'd791};
      8'h52:   n = '{1'b1, 4'd8, 12'd746};
      default: n = '0;
    endcase
    return n;
  endfunction

  logic [7:0]  prev_code, accepted_code;
  logic [3:0]  stab_cnt;
  logic        accept;
  note_t       note;

  state_t      state_q, state_d;
  logic [7:0]  amp_q, amp_d;
  logic [11:0] half_q, half_d;
  logic [9:0]  presc_q, presc_d;
  logic [11:0] tone_q, tone_d;
  logic [3:0]  idx_d;
  logic        sq_d, key_on_d, key_off_d, active_d;
  logic [7:0]  wave_d;
`ifdef KEY_TONE_DECAY_EN
  logic [15:0] decay_q, decay_d;
`endif

  // A code is taken once it has been seen STABLE_CYC samples in a row and differs from the last one taken.
  assign accept = (stab_cnt == STAB_MAX) && (prev_code != accepted_code);
  assign note   = note_lookup(prev_code);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_code     <= 8'h00;
      accepted_code <= REL_CODE;
      stab_cnt      <= '0;
    end else begin
      prev_code <= key_code;
      if (key_code == prev_code) begin
        if (stab_cnt != STAB_MAX) stab_cnt <= stab_cnt + 4'd1;
      end else begin
        stab_cnt <= '0;
      end
      if (accept) accepted_code <= prev_code;
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves a latch behind.
    state_d   = state_q;
    amp_d     = amp_q;
    half_d    = half_q;
    presc_d   = presc_q;
    tone_d    = tone_q;
    idx_d     = note_idx;
    sq_d      = tone_sq;
    key_on_d  = 1'b0;
    key_off_d = 1'b0;
`ifdef KEY_TONE_DECAY_EN
    decay_d   = decay_q;
`endif

    if (state_q != IDLE) begin
      if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        if (tone_q == half_q - 12'd1) begin
          tone_d = '0;
          sq_d   = ~tone_sq;
        end else begin
          tone_d = tone_q + 12'd1;
        end
      end else begin
        presc_d = presc_q + 10'd1;
      end
    end

`ifdef KEY_TONE_DECAY_EN
    if (state_q == RELEASE) begin
      if (amp_q == 8'd0) begin
        state_d = IDLE;
        idx_d   = '0;
        presc_d = '0;
        tone_d  = '0;
        sq_d    = 1'b0;
        decay_d = '0;
      end else if (decay_q == DECAY_MAX) begin
        decay_d = '0;
        amp_d   = amp_q - 8'd1;
      end else begin
        decay_d = decay_q + 16'd1;
      end
    end
`endif

    // Acceptance overrides the free-running tone/envelope update; a note code retriggers from any state.
    if (accept) begin
      if (note.hit) begin
        state_d  = PLAY;
        idx_d    = note.idx;
        half_d   = note.half;
        amp_d    = AMP_INIT;
        presc_d  = '0;
        tone_d   = '0;
        sq_d     = 1'b0;
        key_on_d = 1'b1;
      end else if (prev_code == REL_CODE && state_q == PLAY) begin
        key_off_d = 1'b1;
`ifdef KEY_TONE_DECAY_EN
        state_d   = RELEASE;
        decay_d   = '0;
`else
        state_d   = IDLE;
        amp_d     = '0;
        idx_d     = '0;
        presc_d   = '0;
        tone_d    = '0;
        sq_d      = 1'b0;
`endif
      end
    end

    active_d = (state_d != IDLE);
    wave_d   = sq_d ? amp_d : 8'h00;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      amp_q    <= '0;
      half_q   <= '0;
      presc_q  <= '0;
      tone_q   <= '0;
      note_idx <= '0;
      tone_sq  <= 1'b0;
      key_on   <= 1'b0;
      key_off  <= 1'b0;
      active   <= 1'b0;
      wave_out <= '0;
`ifdef KEY_TONE_DECAY_EN
      decay_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      amp_q    <= amp_d;
      half_q   <= half_d;
      presc_q  <= presc_d;
      tone_q   <= tone_d;
      note_idx <= idx_d;
      tone_sq  <= sq_d;
      key_on   <= key_on_d;
      key_off  <= key_off_d;
      active   <= active_d;
      wave_out <= wave_d;
`ifdef KEY_TONE_DECAY_EN
      decay_q  <= decay_d;
`endif
    end
  end

endmodule

// File: tb/tb_key_tone_decoder.sv
// Bench for key_tone_decoder: timestamp-based reference model compared every cycle, plus directed literal checks.
module tb_key_tone_decoder;

  localparam int STABLE_CYC = 2;
  localparam int PRESCALE   = 4;
  localparam int DECAY_CYC  = 4;
  localparam int AMP_MAX    = 255;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] key_code = 8'hF0;
  logic [3:0] note_idx;
  logic       key_on, key_off, active, tone_sq;
  logic [7:0] wave_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  key_tone_decoder #(
    .STABLE_CYC(STABLE_CYC),
    .PRESCALE  (PRESCALE),
    .DECAY_CYC (DECAY_CYC),
    .AMP_MAX   (AMP_MAX)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .key_code(key_code),
    .note_idx(note_idx),
    .key_on  (key_on),
    .key_off (key_off),
    .active  (active),
    .tone_sq (tone_sq),
    .wave_out(wave_out)
  );

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual %0d, required %0d", name, act, req);
    end
  endtask

  // Reference model: sounding note described by start/release timestamps rather than counters.
  int         tb_cyc = 0;
  logic [7:0] hist[$];
  logic [7:0] m_acc;
  int         m_mode;   // 0 silent, 1 playing, 2 releasing
  int         m_idx, m_half, m_start, m_rel;
  logic [15:0] exp_vec = '0;

  function automatic void table_lookup(input logic [7:0] c, output int idx, output int half);
    idx = 0; half = 0;
    case (c)
      8'h2B: begin idx = 1; half = 1493; end
      8'h34: begin idx = 2; half = 1330; end
      8'h33: begin idx = 3; half = 1185; end
      8'h3B: begin idx = 4; half = 1118; end
      8'h42: begin idx = 5; half = 996;  end
      8'h4B: begin idx = 6; half = 888;  end
      8'h4C: begin idx = 7; half = 791;  end
      8'h52: begin idx = 8; half = 746;  end
      default: ;
    endcase
  endfunction

  task automatic model_reset();
    hist.delete();
    hist.push_back(8'h00);
    m_acc = 8'hF0; m_mode = 0; m_idx = 0; m_half = 0; m_start = 0; m_rel = 0;
    exp_vec = '0;
  endtask

  task automatic model_step();
    logic [7:0] code;
    bit acc, all_eq, on, off;
    int idx, half, amp, sq;
    tb_cyc++;
    code = hist[hist.size()-1];
    acc = 1'b0;
    if (hist.size() >= STABLE_CYC) begin
      all_eq = 1'b1;
      foreach (hist[i]) if (hist[i] != code) all_eq = 1'b0;
      acc = all_eq && (code != m_acc);
    end
    hist.push_back(key_code);
    while (hist.size() > STABLE_CYC) void'(hist.pop_front());

    on = 1'b0; off = 1'b0;
    if (m_mode == 2 && tb_cyc > m_rel + AMP_MAX * DECAY_CYC) m_mode = 0;
    if (acc) begin
      m_acc = code;
      table_lookup(code, idx, half);
      if (idx != 0) begin
        m_mode = 1; m_idx = idx; m_half = half; m_start = tb_cyc; on = 1'b1;
      end else if (code == 8'hF0 && m_mode == 1) begin
        off = 1'b1;
`ifdef KEY_TONE_DECAY_EN
        m_mode = 2; m_rel = tb_cyc;
`else
        m_mode = 0;
`endif
      end
    end

    if (m_mode == 1)      amp = AMP_MAX;
    else if (m_mode == 2) amp = AMP_MAX - (tb_cyc - m_rel) / DECAY_CYC;
    else                  amp = 0;
    if (amp < 0) amp = 0;
    sq = (m_mode != 0) ? ((tb_cyc - m_start) / (PRESCALE * m_half)) % 2 : 0;
    exp_vec = {4'((m_mode != 0) ? m_idx : 0), on, off, (m_mode != 0), sq[0],
               8'((sq != 0) ? amp : 0)};
  endtask

  initial forever begin
    @(posedge clock or negedge reset_n);
    if (!reset_n) model_reset();
    else model_step();
  end

  initial forever begin
    @(negedge clock);
    check($sformatf("cycle %0d outputs", tb_cyc),
          int'({note_idx, key_on, key_off, active, tone_sq, wave_out}), int'(exp_vec));
  end

  // Pulse monitor samples just after the edge, away from the stimulus/compare instants.
  int on_cnt = 0, off_cnt = 0, on_last = 0, off_last = 0;
  initial forever begin
    @(posedge clock);
    #1;
    if (key_on)  begin on_cnt++;  on_last  = tb_cyc; end
    if (key_off) begin off_cnt++; off_last = tb_cyc; end
  end

  task automatic hold(input logic [7:0] c, input int n);
    key_code = c;
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    #1 reset_n = 1'b0;
    key_code = 8'hF0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic wait_level(input logic v, input int bound, input string name, output int t);
    t = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clock);
      if (tone_sq === v) begin
        t = tb_cyc;
        break;
      end
    end
    if (t < 0) check({name, " timeout"}, 0, 1);
  endtask

  initial begin
    #700000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1);
  end

  initial begin
    int first, b_on, b_off, t1, tf, t2, r;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    // Reset state
    check("reset note_idx", note_idx, 0);
    check("reset active", active, 0);
    check("reset wave_out", wave_out, 0);
    check("reset tone_sq", tone_sq, 0);
    check("reset key_on", key_on, 0);

    // Note start, latency and tone period
    first = tb_cyc + 1;
    b_on = on_cnt;
    hold(8'h2B, 10);
    check("2B key_on count", on_cnt - b_on, 1);
    check("2B key_on latency", on_last - first, 2);
    check("2B note_idx", note_idx, 1);
    check("2B active", active, 1);
    wait_level(1'b1, 8000, "2B rise", t1);
    check("2B first half period", t1 - on_last, 5972);
    check("2B wave while high", wave_out, 255);
    wait_level(1'b0, 8000, "2B fall", tf);
    check("2B half period", tf - t1, 5972);
    wait_level(1'b1, 8000, "2B rise2", t2);
    check("2B full period", t2 - t1, 11944);

    // Release
    b_off = off_cnt;
    hold(8'hF0, 3);
    r = tb_cyc;
    check("F0 key_off count", off_cnt - b_off, 1);
    check("F0 key_off cycle", off_last, r);
`ifdef KEY_TONE_DECAY_EN
    check("release active", active, 1);
    repeat (200) @(negedge clock);
    check("release wave at +200", wave_out, 205);
    repeat (819) @(negedge clock);
    check("release wave at +1019", wave_out, 1);
    @(negedge clock);
    check("release wave at +1020", wave_out, 0);
    check("release active at +1020", active, 1);
    @(negedge clock);
    check("release active at +1021", active, 0);
    check("release note_idx at +1021", note_idx, 0);
    check("release key_off total", off_cnt - b_off, 1);
`else
    check("release active drops with key_off", active, 0);
    check("release note_idx", note_idx, 0);
    check("release wave_out", wave_out, 0);
`endif

    // Retrigger sequence 52, F0, 52
    do_reset();
    b_on = on_cnt; b_off = off_cnt;
    hold(8'h52, 5);
    hold(8'hF0, 5);
    hold(8'h52, 5);
    check("52F052 key_on count", on_cnt - b_on, 2);
    check("52F052 key_off count", off_cnt - b_off, 1);
    check("52F052 note_idx", note_idx, 8);
    check("52F052 tone_sq restart", tone_sq, 0);
    wait_level(1'b1, 4000, "52 rise", t1);
    check("52 first half period", t1 - on_last, 2984);
    check("52 amp restored", wave_out, 255);

    // Glitch rejection
    do_reset();
    b_on = on_cnt; b_off = off_cnt;
    hold(8'hF0, 3);
    hold(8'h42, 1);
    hold(8'hF0, 5);
    check("glitch key_on count", on_cnt - b_on, 0);
    check("glitch active", active, 0);

    // Unknown code and F0 while idle, then a real note
    hold(8'h1C, 5);
    hold(8'hF0, 5);
    check("idle codes key_on", on_cnt - b_on, 0);
    check("idle codes key_off", off_cnt - b_off, 0);
    check("idle codes active", active, 0);
    hold(8'h4C, 5);
    check("4C key_on count", on_cnt - b_on, 1);
    check("4C note_idx", note_idx, 7);

    // Retrigger from PLAY, then asynchronous reset mid-note
    hold(8'h4B, 5);
    check("4B retrigger key_on count", on_cnt - b_on, 2);
    check("4B note_idx", note_idx, 6);
    wait_level(1'b1, 5000, "4B rise", t1);
    check("4B wave before reset", wave_out, 255);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("async reset wave_out", wave_out, 0);
    check("async reset active", active, 0);
    check("async reset tone_sq", tone_sq, 0);
    check("async reset note_idx", note_idx, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    b_on = on_cnt;
    hold(8'h4B, 5);
    check("post-reset 4B key_on", on_cnt - b_on, 1);
    check("post-reset 4B note_idx", note_idx, 6);
    check("post-reset 4B active", active, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
